// File: rtl/triad_frame_collector.sv
// Triad frame collector: captures N pulse ids plus polynomial on each id_ready rising edge,
// queues them in a frame FIFO and presents them over valid/ack. Optional macro: TRIAD_FRAME_TS_EN.
module triad_frame_collector #(
  parameter int N_CHANNELS = 3,
  parameter int ID_WIDTH   = 17,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 24,
`ifdef TRIAD_FRAME_TS_EN
  localparam int FRAME_W   = (N_CHANNELS + 1) * ID_WIDTH + TS_WIDTH,
`else
  localparam int FRAME_W   = (N_CHANNELS + 1) * ID_WIDTH,
`endif
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           clk_72MHz,
  input  logic                           reset,
  input  logic [N_CHANNELS*ID_WIDTH-1:0] pulse_id,
  input  logic [ID_WIDTH-1:0]            polynomial,
  input  logic                           id_ready,
  input  logic [TS_WIDTH-1:0]            sys_ts,
  output logic [FRAME_W-1:0]             frame_data,
  output logic                           frame_valid,
  input  logic                           frame_ack,
  output logic [LVL_W-1:0]               fifo_level,
  output logic [7:0]                     drop_count,
  output logic                           reset_identifier
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Handshake: frame_valid/frame_data hold the FIFO head; a cycle with
  // frame_valid=1 and frame_ack=1 pops it. frame_ack with frame_valid=0 is ignored.
  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 id_ready_q, id_ready_d;
  logic                 cap_valid_q, cap_valid_d;
  logic [FRAME_W-1:0]   cap_frame_q, cap_frame_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [7:0]           drop_q, drop_d;
  logic [FRAME_W-1:0]   mem_q [FIFO_DEPTH];

  logic                 capture;
  logic [FRAME_W-1:0]   new_frame;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

`ifdef TRIAD_FRAME_TS_EN
  assign new_frame = {sys_ts, pulse_id, polynomial};
`else
  logic unused_sys_ts;
  assign unused_sys_ts = ^sys_ts;
  assign new_frame     = {pulse_id, polynomial};
`endif

  // Edge detection and one-cycle capture stage feeding the FIFO write.
  always_comb begin
    capture     = id_ready & ~id_ready_q;
    id_ready_d  = id_ready;
    cap_valid_d = capture;
    cap_frame_d = capture ? new_frame : cap_frame_q;
  end

  always_comb begin
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    pop      = (state_q == ST_PRESENT) && frame_ack;
    push     = cap_valid_q && (!full || pop);
    drop     = cap_valid_q && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    drop_d   = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  // Next state looks at the post-update level so a push into an empty FIFO
  // is presented on the very next cycle and a refilled FIFO never bubbles.
  always_comb begin
    state_d     = state_q;
    frame_valid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (level_d != '0) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        frame_valid = 1'b1;
        if (level_d == '0) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign frame_data       = frame_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level       = level_q;
  assign drop_count       = drop_q;
  assign reset_identifier = cap_valid_q;

  // The edge register resets high so an id_ready held across reset must
  // first be seen low before it can produce a capture.
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      id_ready_q  <= 1'b1;
      cap_valid_q <= 1'b0;
      cap_frame_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      id_ready_q  <= id_ready_d;
      cap_valid_q <= cap_valid_d;
      cap_frame_q <= cap_frame_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk_72MHz) begin
    if (push) mem_q[wr_ptr_q] <= cap_frame_q;
  end

endmodule
